countdown_timer: RTL and testbench

- Loadable 32-bit down-counter timer. It is the decrementing, expiry-signalling counterpart to the team's free-running up-counter.
- Software or an upstream FSM loads a value through a valid/ready handshake, starts the timer, and can pause or resume it.
- The block emits a one-cycle expire pulse when the count reaches terminal.
- Supports one-shot and periodic (auto-reload) modes. Used for watchdogs, timeouts and periodic ticks.

---
 rtl/countdown_timer.sv | 135 +++++++++++++
 tb/tb_countdown_timer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter timer with valid/ready load, start/stop control and a
// one-cycle expire pulse; one-shot or periodic. Optional prescaler: COUNTDOWN_TIMER_PRESCALE_EN.
//
//   state   | meaning
//   IDLE    | out of reset, nothing loaded
//   ARMED   | value loaded or paused, waiting for start
//   RUNNING | counting down, loads refused
//   DONE    | one-shot (or zero load) expired, cnt=0
module countdown_timer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             load_periodic,
   input  logic             start,
   input  logic             stop,
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
   input  logic [7:0]       prescale,
`endif
   output logic [WIDTH-1:0] cnt,
   output logic             running,
   output logic             expire
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RUNNING = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             periodic_q, periodic_d;
   logic             expire_q, expire_d;
   logic             load_acc;
   logic             tick;

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
   logic [7:0]       psc_q, psc_d;
   assign tick = (psc_q == prescale);
`else
   assign tick = 1'b1;
`endif

   assign load_acc   = load_valid && (state_q != ST_RUNNING);
   assign load_ready = (state_q != ST_RUNNING);
   assign running    = (state_q == ST_RUNNING);
   assign cnt        = cnt_q;
   assign expire     = expire_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      reload_d   = reload_q;
      periodic_d = periodic_q;
      expire_d   = 1'b0;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
      psc_d      = psc_q;
`endif
      case (state_q)
         ST_ARMED: begin
            if (start) begin
               state_d = ST_RUNNING;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
               psc_d   = 8'd0;
`endif
            end
         end
         ST_RUNNING: begin
            // stop wins over decrement and expiry, so a pause never expires
            if (stop) begin
               state_d = ST_ARMED;
            end else begin
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
               psc_d = tick ? 8'd0 : psc_q + 8'd1;
`endif
               if (tick) begin
                  if (cnt_q == '0) begin
                     expire_d = 1'b1;
                     state_d  = ST_DONE;
                  end else if (cnt_q == WIDTH'(1)) begin
                     expire_d = 1'b1;
                     if (periodic_q) begin
                        cnt_d = reload_q;
                     end else begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                     end
                  end else begin
                     cnt_d = cnt_q - WIDTH'(1);
                  end
               end
            end
         end
         default: ;
      endcase
      if (load_acc) begin
         cnt_d      = load_value;
         reload_d   = load_value;
         periodic_d = load_periodic;
         state_d    = ST_ARMED;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
         psc_d      = 8'd0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         reload_q   <= '0;
         periodic_q <= 1'b0;
         expire_q   <= 1'b0;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
         psc_q      <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         reload_q   <= reload_d;
         periodic_q <= periodic_d;
         expire_q   <= expire_d;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
         psc_q      <= psc_d;
`endif
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed-vector bench for countdown_timer: the driver queues hand-computed
// post-edge outputs, a separate monitor pops and compares them after each edge.
module tb_countdown_timer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_value;
   logic        load_periodic;
   logic        start;
   logic        stop;
   logic [31:0] cnt;
   logic        running;
   logic        expire;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
   logic [7:0]  prescale = 8'd0;
`endif

   typedef struct {
      logic [31:0] cnt;
      logic        run;
      logic        exp;
      logic        rdy;
      int          id;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_id = 0;
   bit   drv_done = 1'b0;

   always #5 clk = ~clk;

   countdown_timer #(.WIDTH(32)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_value   (load_value),
      .load_periodic(load_periodic),
      .start        (start),
      .stop         (stop),
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
      .prescale     (prescale),
`endif
      .cnt          (cnt),
      .running      (running),
      .expire       (expire)
   );

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic v(input bit r, input bit lv, input logic [31:0] val, input bit per,
                    input bit st, input bit sp,
                    input logic [31:0] ec, input bit er, input bit ee, input bit ey);
      exp_t e;
      @(negedge clk);
      rstn          = r;
      load_valid    = lv;
      load_value    = val;
      load_periodic = per;
      start         = st;
      stop          = sp;
      e.cnt = ec; e.run = er; e.exp = ee; e.rdy = ey; e.id = vec_id;
      exp_q.push_back(e);
      vec_id++;
   endtask

   task automatic idle_n(input int n, input logic [31:0] ec, input bit er, input bit ey);
      for (int i = 0; i < n; i++) v(1, 0, 0, 0, 0, 0, ec, er, 1'b0, ey);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (cnt !== e.cnt) begin
               errors++;
               $display("FAIL cnt vec %0d: got %0d expected %0d", e.id, cnt, e.cnt);
            end
            checks++;
            if (running !== e.run) begin
               errors++;
               $display("FAIL running vec %0d: got %b expected %b", e.id, running, e.run);
            end
            checks++;
            if (expire !== e.exp) begin
               errors++;
               $display("FAIL expire vec %0d: got %b expected %b", e.id, expire, e.exp);
            end
            checks++;
            if (load_ready !== e.rdy) begin
               errors++;
               $display("FAIL load_ready vec %0d: got %b expected %b", e.id, load_ready, e.rdy);
            end
         end
      end
   end

   initial begin : driver
      rstn = 1'b0; load_valid = 1'b0; load_value = '0; load_periodic = 1'b0;
      start = 1'b0; stop = 1'b0;
      // reset, then start/stop in IDLE are ignored
      v(0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      v(0, 0, 0, 0, 1, 0,   0, 0, 0, 1);
      v(1, 0, 0, 0, 1, 1,   0, 0, 0, 1);
      // one-shot 5
      v(1, 1, 5, 0, 0, 0,   5, 0, 0, 1);
      v(1, 0, 0, 0, 1, 0,   5, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   4, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   3, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   2, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   1, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   0, 0, 1, 1);
      v(1, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      v(1, 0, 0, 0, 1, 1,   0, 0, 0, 1);
      // periodic 3, four periods, then stop
      v(1, 1, 3, 1, 0, 0,   3, 0, 0, 1);
      v(1, 0, 0, 0, 1, 0,   3, 1, 0, 0);
      for (int p = 0; p < 4; p++) begin
         v(1, 0, 0, 0, 0, 0,   2, 1, 0, 0);
         v(1, 0, 0, 0, 0, 0,   1, 1, 0, 0);
         v(1, 0, 0, 0, 0, 0,   3, 1, 1, 0);
      end
      v(1, 0, 0, 0, 0, 1,   3, 0, 0, 1);
      // in ARMED: load beats start, stop ignored
      v(1, 1, 10, 0, 1, 0, 10, 0, 0, 1);
      v(1, 0, 0, 0, 0, 1,  10, 0, 0, 1);
      // pause at 6 for 5 cycles (first with start too), then resume
      v(1, 0, 0, 0, 1, 0,  10, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   9, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   8, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   7, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   6, 1, 0, 0);
      v(1, 0, 0, 0, 1, 1,   6, 0, 0, 1);
      idle_n(4, 6, 0, 1);
      v(1, 0, 0, 0, 1, 0,   6, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   5, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   4, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   3, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   2, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   1, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   0, 0, 1, 1);
      // stop on the edge where cnt==1 suppresses expiry
      v(1, 1, 2, 0, 0, 0,   2, 0, 0, 1);
      v(1, 0, 0, 0, 1, 0,   2, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   1, 1, 0, 0);
      v(1, 0, 0, 0, 0, 1,   1, 0, 0, 1);
      v(1, 0, 0, 0, 1, 0,   1, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   0, 0, 1, 1);
      v(1, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      // zero load, periodic flag ignored
      v(1, 1, 0, 1, 0, 0,   0, 0, 0, 1);
      v(1, 0, 0, 0, 1, 0,   0, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   0, 0, 1, 1);
      v(1, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      // periodic 1 expires every cycle
      v(1, 1, 1, 1, 0, 0,   1, 0, 0, 1);
      v(1, 0, 0, 0, 1, 0,   1, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   1, 1, 1, 0);
      v(1, 0, 0, 0, 0, 0,   1, 1, 1, 0);
      v(1, 0, 0, 0, 0, 0,   1, 1, 1, 0);
      v(1, 0, 0, 0, 0, 1,   1, 0, 0, 1);
      // load 8; loads while running are refused
      v(1, 1, 8, 0, 0, 0,   8, 0, 0, 1);
      v(1, 0, 0, 0, 1, 0,   8, 1, 0, 0);
      v(1, 1, 99, 0, 0, 0,  7, 1, 0, 0);
      v(1, 1, 1, 1, 0, 0,   6, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   5, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   4, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   3, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   2, 1, 0, 0);
      v(1, 0, 0, 0, 0, 0,   1, 1, 0, 0);
      // reset at cnt==1 aborts with no expire
      v(0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      v(1, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      v(1, 0, 0, 0, 1, 0,   0, 0, 0, 1);
      drv_done = 1'b1;
   end

   initial begin : finisher
      int guard;
      guard = 0;
      while (!drv_done && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (!drv_done || exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: done=%b pending=%0d expected done=1 pending=0", drv_done, exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
